// File: rtl/ps2_keys_decoder.sv
// PS/2 keyboard receiver (scan code set 2) turning make/break codes into
// held-key levels for two players: W/S/A/D for player 1, arrows for player 2.
module ps2_keys_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       j1_up,
    output logic       j1_down,
    output logic       j1_left,
    output logic       j1_right,
    output logic       j2_up,
    output logic       j2_down,
    output logic       j2_left,
    output logic       j2_right,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = 4;
    localparam int unsigned KW = 8;
    localparam int unsigned SW = 10;

    typedef enum logic [1:0] {R_IDLE, R_RECV, R_CHECK} rx_state_e;
    typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dec_state_e;

    // Key bit order: j1 up/down/left/right in [3:0], j2 up/down/left/right in [7:4]
    function automatic logic [KW-1:0] key_mask(input logic [7:0] b, input logic ext);
        logic [KW-1:0] m;
        m = '0;
        case ({ext, b})
            9'h01D:  m = 8'h01;
            9'h01B:  m = 8'h02;
            9'h01C:  m = 8'h04;
            9'h023:  m = 8'h08;
            9'h175:  m = 8'h10;
            9'h172:  m = 8'h20;
            9'h16B:  m = 8'h40;
            9'h174:  m = 8'h80;
            default: m = '0;
        endcase
        return m;
    endfunction

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;

    rx_state_e     rx_state_q, rx_state_d;
    dec_state_e    dec_state_q, dec_state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [KW-1:0] keys_q, keys_d;
    logic [7:0]    code_q, code_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_err_q, frame_err_d;

    logic [7:0]    rx_byte;
    logic          frame_ok;
    logic [KW-1:0] mask_std, mask_ext;

    assign rx_byte  = shift_q[7:0];
    assign frame_ok = (^shift_q[8:0]) & shift_q[9];
    assign mask_std = key_mask(rx_byte, 1'b0);
    assign mask_ext = key_mask(rx_byte, 1'b1);

    // Two-flop synchronisers for the asynchronous PS/2 pins (idle high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Glitch filter: flip only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    // Filter and falling-edge strobe registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    // Receiver and make/break decoder next-state and output logic
    always_comb begin
        rx_state_d   = rx_state_q;
        dec_state_d  = dec_state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_cnt_d    = tmo_cnt_q;
        keys_d       = keys_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (rx_state_q)
            R_IDLE: begin
                tmo_cnt_d = '0;
                if (fall_q && !data_s2_q) begin
                    bit_cnt_d  = BW'(1);
                    rx_state_d = R_RECV;
                end
            end
            R_RECV: begin
                if (fall_q) begin
                    shift_d   = {data_s2_q, shift_q[SW-1:1]};
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == BW'(10)) begin
                        bit_cnt_d  = '0;
                        rx_state_d = R_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    // Stalled partial frame: drop it without flagging an error
                    bit_cnt_d  = '0;
                    tmo_cnt_d  = '0;
                    rx_state_d = R_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            R_CHECK: begin
                rx_state_d = R_IDLE;
                if (frame_ok) begin
                    code_d       = rx_byte;
                    code_valid_d = 1'b1;
                    case (dec_state_q)
                        D_IDLE: begin
                            if (rx_byte == 8'hE0) begin
                                dec_state_d = D_E0;
                            end else if (rx_byte == 8'hF0) begin
                                dec_state_d = D_F0;
                            end else if (rx_byte == 8'h00 || rx_byte == 8'hFF) begin
                                keys_d = '0;
                            end else begin
                                keys_d = keys_q | mask_std;
                            end
                        end
                        D_E0: begin
                            if (rx_byte == 8'hF0) begin
                                dec_state_d = D_E0F0;
                            end else if (rx_byte != 8'hE0) begin
                                keys_d      = keys_q | mask_ext;
                                dec_state_d = D_IDLE;
                            end
                        end
                        D_F0: begin
                            keys_d      = keys_q & ~mask_std;
                            dec_state_d = D_IDLE;
                        end
                        D_E0F0: begin
                            keys_d      = keys_q & ~mask_ext;
                            dec_state_d = D_IDLE;
                        end
                        default: dec_state_d = D_IDLE;
                    endcase
                end else begin
                    frame_err_d = 1'b1;
                    dec_state_d = D_IDLE;
                end
            end
            default: begin
                rx_state_d = R_IDLE;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= R_IDLE;
            dec_state_q  <= D_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_cnt_q    <= '0;
            keys_q       <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            dec_state_q  <= dec_state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_cnt_q    <= tmo_cnt_d;
            keys_q       <= keys_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign j1_up      = keys_q[0];
    assign j1_down    = keys_q[1];
    assign j1_left    = keys_q[2];
    assign j1_right   = keys_q[3];
    assign j2_up      = keys_q[4];
    assign j2_down    = keys_q[5];
    assign j2_left    = keys_q[6];
    assign j2_right   = keys_q[7];
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keys_decoder.sv
// Scoreboard bench for ps2_keys_decoder: expected pulses are queued as frames
// are sent and matched against code_valid / frame_err as they appear.
module tb_ps2_keys_decoder;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 300;
    localparam int unsigned HALF       = 20;

    localparam int M_IDLE = 0, M_E0 = 1, M_F0 = 2, M_E0F0 = 3;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic [7:0] keys;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       j1_up, j1_down, j1_left, j1_right;
    logic       j2_up, j2_down, j2_left, j2_right;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic [7:0] keys_o;

    int         n_total = 0;
    int         n_bad   = 0;
    exp_t       sb_q[$];

    int         m_state = M_IDLE;
    logic [7:0] m_keys  = 8'h00;
    logic [7:0] m_code  = 8'h00;

    assign keys_o = {j2_right, j2_left, j2_down, j2_up, j1_right, j1_left, j1_down, j1_up};

    ps2_keys_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .j1_up(j1_up), .j1_down(j1_down), .j1_left(j1_left), .j1_right(j1_right),
        .j2_up(j2_up), .j2_down(j2_down), .j2_left(j2_left), .j2_right(j2_right),
        .code(code), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Spec key table, bit order matches keys_o
    function automatic logic [7:0] ref_mask(input logic [7:0] b, input logic ext);
        if (!ext) begin
            if (b == 8'h1D) return 8'h01;
            if (b == 8'h1B) return 8'h02;
            if (b == 8'h1C) return 8'h04;
            if (b == 8'h23) return 8'h08;
        end else begin
            if (b == 8'h75) return 8'h10;
            if (b == 8'h72) return 8'h20;
            if (b == 8'h6B) return 8'h40;
            if (b == 8'h74) return 8'h80;
        end
        return 8'h00;
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF / 2) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        exp_t e;
        if (bad_par || bad_stop) begin
            m_state = M_IDLE;
            e.is_err = 1'b1;
        end else begin
            m_code = b;
            e.is_err = 1'b0;
            case (m_state)
                M_IDLE: begin
                    if (b == 8'hE0) m_state = M_E0;
                    else if (b == 8'hF0) m_state = M_F0;
                    else if (b == 8'h00 || b == 8'hFF) m_keys = 8'h00;
                    else m_keys = m_keys | ref_mask(b, 1'b0);
                end
                M_E0: begin
                    if (b == 8'hF0) m_state = M_E0F0;
                    else if (b != 8'hE0) begin
                        m_keys  = m_keys | ref_mask(b, 1'b1);
                        m_state = M_IDLE;
                    end
                end
                M_F0: begin
                    m_keys  = m_keys & ~ref_mask(b, 1'b0);
                    m_state = M_IDLE;
                end
                default: begin
                    m_keys  = m_keys & ~ref_mask(b, 1'b1);
                    m_state = M_IDLE;
                end
            endcase
        end
        e.code = m_code;
        e.keys = m_keys;
        sb_q.push_back(e);
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
        repeat (10) @(posedge clk);
        #1;
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    // Monitor: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (code_valid || frame_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_err, code_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("frame_err", 32'(frame_err), 32'(e.is_err));
                chk("code_valid", 32'(code_valid), 32'(!e.is_err));
                chk("code", 32'(code), 32'(e.code));
                chk("keys", 32'(keys_o), 32'(e.keys));
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_keys", 32'(keys_o), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(posedge clk);

        // Plain make, then break
        send_byte(8'h1D);
        chk("j1_up_make", 32'(keys_o), 32'h01);
        send_byte(8'hF0);
        send_byte(8'h1D);
        chk("j1_up_break", 32'(keys_o), 32'h00);

        // Extended makes and break
        send_byte(8'hE0); send_byte(8'h75);
        chk("j2_up_make", 32'(keys_o), 32'h10);
        send_byte(8'hE0); send_byte(8'h6B);
        chk("j2_left_make", 32'(keys_o), 32'h50);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        chk("j2_up_break", 32'(keys_o), 32'h40);

        // Bad parity, bad stop, and decoder reset by an error
        send_frame(8'h23, 1'b1, 1'b0);
        chk("bad_par_j1_right", 32'(j1_right), 32'd0);
        send_byte(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_byte(8'h1C);
        chk("err_resets_dec", 32'(keys_o), 32'h44);

        // Stalled partial frame followed by a clean frame
        send_bits(11'b000_0110_1010, 5);
        repeat (TIMEOUT + 10) @(posedge clk);
        send_byte(8'h1B);
        chk("timeout_code", 32'(code), 32'h1B);
        chk("timeout_keys", 32'(keys_o), 32'h46);

        // Unmapped codes, repeated makes, E0 E0 prefix
        send_byte(8'hE0); send_byte(8'h1D);
        send_byte(8'h75); send_byte(8'hAA); send_byte(8'hFA);
        send_byte(8'h1D); send_byte(8'h1D);
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h74);
        chk("hold_many", 32'(keys_o), 32'hC7);

        // Overrun code clears everything
        send_byte(8'h00);
        chk("overrun_clear", 32'(keys_o), 32'h00);
        send_byte(8'h23); send_byte(8'hE0); send_byte(8'h72);
        chk("opposing_ok", 32'(keys_o), 32'h28);

        // Reset in the middle of a frame
        send_bits(11'b000_1100_1010, 5);
        reset_n = 1'b0;
        #1;
        chk("midrst_keys", 32'(keys_o), 32'd0);
        chk("midrst_code", 32'(code), 32'd0);
        sb_q.delete();
        m_state = M_IDLE;
        m_keys  = 8'h00;
        m_code  = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(posedge clk);
        send_byte(8'h1D);
        chk("post_rst_decode", 32'(keys_o), 32'h01);
        chk("post_rst_code", 32'(code), 32'h1D);

        repeat (20) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
